// File: rtl/alu_result_stage_pkg.sv
// Shared constants for the ALU result stage: branch condition codes, flag
// bit positions and ALU op codes.
package alu_result_stage_pkg;

    localparam int NFLAGS = 3;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;

    typedef enum logic [2:0] {
        COND_NEVER  = 3'd0,
        COND_ALWAYS = 3'd1,
        COND_EQ     = 3'd2,
        COND_NE     = 3'd3,
        COND_CS     = 3'd4,
        COND_CC     = 3'd5,
        COND_VS     = 3'd6,
        COND_VC     = 3'd7
    } cond_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SHL = 3'd5,
        ALU_SHR = 3'd6,
        ALU_PASS = 3'd7
    } alu_op_e;

endpackage

// File: rtl/alu_cond_eval.sv
// Combinational branch resolution: condition code against {V,C,Z} flags.
module alu_cond_eval
    import alu_result_stage_pkg::*;
(
    input  logic [2:0]        cond_i,
    input  logic [NFLAGS-1:0] flags_i,
    output logic              take_o
);

    always_comb begin
        take_o = 1'b0;
        case (cond_e'(cond_i))
            COND_NEVER:  take_o = 1'b0;
            COND_ALWAYS: take_o = 1'b1;
            COND_EQ:     take_o =  flags_i[FLAG_Z];
            COND_NE:     take_o = ~flags_i[FLAG_Z];
            COND_CS:     take_o =  flags_i[FLAG_C];
            COND_CC:     take_o = ~flags_i[FLAG_C];
            COND_VS:     take_o =  flags_i[FLAG_V];
            COND_VC:     take_o = ~flags_i[FLAG_V];
            default:     take_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage: flag register, branch resolution and a small
// result FIFO with registered head outputs toward writeback.
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int RD_W  = 4,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_result,
    input  logic              in_zero,
    input  logic              in_co,
    input  logic              in_overflow,
    input  logic              in_flag_we,
    input  logic [2:0]        in_cond,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_result,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_take,
    output logic [NFLAGS-1:0] flags
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0]  mem_result_q [DEPTH];
    logic [RD_W-1:0]   mem_rd_q     [DEPTH];
    logic              mem_take_q   [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic [NFLAGS-1:0] flags_q, flags_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_result_q, out_result_d;
    logic [RD_W-1:0]   out_rd_q, out_rd_d;
    logic              out_take_q, out_take_d;

    logic              accept, pop, take;
    logic [NFLAGS-1:0] in_flags, eff_flags;

    assign in_flags  = {in_overflow, in_co, in_zero};
    assign eff_flags = in_flag_we ? in_flags : flags_q;

    alu_cond_eval u_cond (
        .cond_i  (in_cond),
        .flags_i (eff_flags),
        .take_o  (take)
    );

    always_comb begin
        accept       = in_valid & in_ready_q & ~flush;
        pop          = out_valid_q & out_ready & ~flush;
        head_d       = flush ? '0 : head_q + PTR_W'(pop);
        tail_d       = flush ? '0 : tail_q + PTR_W'(accept);
        count_d      = flush ? '0 : count_q + CNT_W'(accept) - CNT_W'(pop);
        in_ready_d   = count_d < CNT_W'(DEPTH);
        flags_d      = (accept & in_flag_we) ? in_flags : flags_q;
        out_valid_d  = count_d != '0;
        out_result_d = out_result_q;
        out_rd_d     = out_rd_q;
        out_take_d   = out_take_q;
        // Head output is preloaded from next-state; the incoming entry bypasses
        // storage when it lands directly at the new head.
        if (count_d != '0) begin
            if (accept && tail_q == head_d) begin
                out_result_d = in_result;
                out_rd_d     = in_rd;
                out_take_d   = take;
            end else begin
                out_result_d = mem_result_q[head_d];
                out_rd_d     = mem_rd_q[head_d];
                out_take_d   = mem_take_q[head_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_result_q[tail_q] <= in_result;
            mem_rd_q[tail_q]     <= in_rd;
            mem_take_q[tail_q]   <= take;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            in_ready_q   <= 1'b1;
            flags_q      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_rd_q     <= '0;
            out_take_q   <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            flags_q      <= flags_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_rd_q     <= out_rd_d;
            out_take_q   <= out_take_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign flags      = flags_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_rd     = out_rd_q;
    assign out_take   = out_take_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: one task per scenario, inline checks.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready;
    logic [15:0] in_result;
    logic        in_zero, in_co, in_overflow, in_flag_we;
    logic [2:0]  in_cond;
    logic [3:0]  in_rd;
    logic        out_valid, out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_rd;
    logic        out_take;
    logic [2:0]  flags;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(16), .RD_W(4), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_zero(in_zero), .in_co(in_co), .in_overflow(in_overflow),
        .in_flag_we(in_flag_we), .in_cond(in_cond), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_take(out_take), .flags(flags)
    );

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] res, input logic z,
                         input logic c, input logic o, input logic we,
                         input logic [2:0] cond, input logic [3:0] rd);
        in_valid = v; in_result = res; in_zero = z; in_co = c;
        in_overflow = o; in_flag_we = we; in_cond = cond; in_rd = rd;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(0, 16'h0, 0, 0, 0, 0, 3'd0, 4'd0);
        step(); step();
        reset = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (flags !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", flags); end
        total++; if (out_result !== 16'd0 || out_rd !== 4'd0 || out_take !== 1'b0) begin
            bad++; $display("FAIL reset_out_data got=%0d/%0d/%b want=0/0/0", out_result, out_rd, out_take); end
    endtask

    task automatic test_add_eq();
        out_ready = 1'b1;
        drive(1, 16'd220, 0, 0, 0, 1, 3'd2, 4'd3);
        step();
        drive(0, 16'h0, 0, 0, 0, 0, 3'd0, 4'd0);
        total++; if (out_valid !== 1'b1 || out_result !== 16'd220 || out_rd !== 4'd3) begin
            bad++; $display("FAIL add_head got v=%b r=%0d rd=%0d want v=1 r=220 rd=3", out_valid, out_result, out_rd); end
        total++; if (out_take !== 1'b0) begin bad++; $display("FAIL add_take got=%b want=0", out_take); end
        total++; if (flags !== 3'b000) begin bad++; $display("FAIL add_flags got=%b want=000", flags); end
        step();
        total++; if (out_valid !== 1'b0 || out_result !== 16'd220) begin
            bad++; $display("FAIL add_hold got v=%b r=%0d want v=0 r=220", out_valid, out_result); end
    endtask

    task automatic test_zero_branch();
        out_ready = 1'b0;
        drive(1, 16'd0, 1, 0, 0, 1, 3'd2, 4'd1);
        step();
        total++; if (out_take !== 1'b1 || out_valid !== 1'b1) begin
            bad++; $display("FAIL zero_eq_take got v=%b t=%b want v=1 t=1", out_valid, out_take); end
        total++; if (flags !== 3'b001) begin bad++; $display("FAIL zero_flags got=%b want=001", flags); end
        drive(1, 16'd5, 0, 0, 0, 0, 3'd3, 4'd2);
        step();
        drive(0, 16'h0, 0, 0, 0, 0, 3'd0, 4'd0);
        out_ready = 1'b1;
        step();
        total++; if (out_take !== 1'b0 || out_result !== 16'd5 || out_rd !== 4'd2) begin
            bad++; $display("FAIL zero_ne_take got t=%b r=%0d rd=%0d want t=0 r=5 rd=2", out_take, out_result, out_rd); end
        step();
        total++; if (out_valid !== 1'b0 || flags !== 3'b001) begin
            bad++; $display("FAIL zero_drain got v=%b f=%b want v=0 f=001", out_valid, flags); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1, 16'd1, 0, 0, 0, 0, 3'd0, 4'd0);
        step();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready1 got=%b want=1", in_ready); end
        drive(1, 16'd2, 0, 0, 0, 0, 3'd0, 4'd0);
        step();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%b want=0", in_ready); end
        drive(1, 16'd3, 0, 0, 0, 0, 3'd0, 4'd0);
        step();
        total++; if (in_ready !== 1'b0 || out_result !== 16'd1) begin
            bad++; $display("FAIL bp_held got rdy=%b r=%0d want rdy=0 r=1", in_ready, out_result); end
        out_ready = 1'b1;
        step();
        total++; if (out_result !== 16'd2 || in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_pop1 got r=%0d rdy=%b want r=2 rdy=1", out_result, in_ready); end
        step();
        drive(0, 16'h0, 0, 0, 0, 0, 3'd0, 4'd0);
        total++; if (out_result !== 16'd3 || out_valid !== 1'b1) begin
            bad++; $display("FAIL bp_pop2 got r=%0d v=%b want r=3 v=1", out_result, out_valid); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b want=0", out_valid); end
    endtask

    task automatic test_cond_codes();
        logic [7:0] exp_tbl;
        exp_tbl = 8'b1001_1010;  // {V,C,Z}=010: bit i is the take for cond i
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1, 16'(i), 0, 1, 0, 1, 3'(i), 4'(i));
            step();
            total++; if (out_take !== exp_tbl[i] || out_result !== 16'(i)) begin
                bad++; $display("FAIL cond_%0d got t=%b r=%0d want t=%b r=%0d", i, out_take, out_result, exp_tbl[i], i); end
        end
        // Restore Z-only flags for the following scenarios.
        drive(1, 16'd0, 1, 0, 0, 1, 3'd0, 4'd0);
        step();
        drive(0, 16'h0, 0, 0, 0, 0, 3'd0, 4'd0);
        step();
        total++; if (flags !== 3'b001 || out_valid !== 1'b0) begin
            bad++; $display("FAIL cond_restore got f=%b v=%b want f=001 v=0", flags, out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(1, 16'h1111, 0, 0, 0, 0, 3'd0, 4'd4);
        step();
        drive(1, 16'h7FFF, 0, 0, 0, 0, 3'd1, 4'd5);
        out_ready = 1'b1;
        step();
        drive(0, 16'h0, 0, 0, 0, 0, 3'd0, 4'd0);
        total++; if (out_result !== 16'h7FFF || out_valid !== 1'b1 || out_take !== 1'b1) begin
            bad++; $display("FAIL b2b_head got r=%h v=%b t=%b want r=7fff v=1 t=1", out_result, out_valid, out_take); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", in_ready); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_count1 got=%b want=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1, 16'd10, 0, 0, 0, 0, 3'd0, 4'd0);
        step();
        drive(1, 16'd11, 0, 0, 0, 0, 3'd0, 4'd0);
        step();
        drive(1, 16'd12, 0, 1, 1, 1, 3'd1, 4'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(0, 16'h0, 0, 0, 0, 0, 3'd0, 4'd0);
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_state got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
        total++; if (flags !== 3'b001) begin bad++; $display("FAIL flush_flags got=%b want=001", flags); end
        out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_discard got=%b want=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1, 16'hAAAA, 1, 1, 1, 1, 3'd0, 4'd7);
        step();
        drive(1, 16'hBBBB, 0, 0, 0, 0, 3'd0, 4'd6);
        step();
        drive(0, 16'h0, 0, 0, 0, 0, 3'd0, 4'd0);
        total++; if (flags !== 3'b111 || in_ready !== 1'b0) begin
            bad++; $display("FAIL rst_setup got f=%b rdy=%b want f=111 rdy=0", flags, in_ready); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (out_valid !== 1'b0 || flags !== 3'b000 || out_result !== 16'd0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_mid got v=%b f=%b r=%h rdy=%b want v=0 f=000 r=0 rdy=1",
                            out_valid, flags, out_result, in_ready); end
        out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_dropped got=%b want=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_add_eq();
        test_zero_branch();
        test_backpressure();
        test_cond_codes();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
